// File: rtl/demod_frame_ctrl.sv
// demod_frame_ctrl: runs one demodulator receive session on clk_fast.
// Holds the demodulator in soft reset, waits for header sync under a timeout
// with bounded re-arms, then deserialises FRAME_BYTES bytes MSB-first and
// presents them to the frame layer over a valid/ready port.
module demod_frame_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int SYNC_TIMEOUT = 1000000,
  parameter int FRAME_BYTES  = 8,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk_fast,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       demod_valid,
  input  logic       demod_bit,
  input  logic       bit_strobe,
  output logic       demod_rst_n,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       frame_done,
  output logic       busy,
  output logic       sync_fail,
  output logic       overflow,
  output logic [2:0] retry_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_SYNC,
    S_RECEIVE,
    S_DRAIN,
    S_FAIL
  } state_t;

  // Counter widths; a limit of 1 still needs a 1-bit counter.
  localparam int ARM_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int TMR_W  = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
  localparam int BYTE_W = $clog2(FRAME_BYTES + 1);

  localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SYNC_TIMEOUT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(FRAME_BYTES - 1);
  localparam logic [2:0]        RETRY_MAX = 3'(MAX_RETRY);

  state_t state;
  state_t state_nxt;

  logic [ARM_W-1:0]  arm_cnt;
  logic [TMR_W-1:0]  sync_tmr;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] byte_cnt;
  logic [6:0]        shift_reg;

  logic session_start;
  logic bit_take;
  logic byte_done;
  logic last_byte;
  logic sync_lost;
  logic tmr_expired;
  logic retry_ok;
  logic handshake;

  // A new session may only be opened from IDLE or FAIL, and abort overrides it.
  assign session_start = start && !abort && ((state == S_IDLE) || (state == S_FAIL));
  // Bits are only taken while receiving and while the demodulator claims lock.
  assign bit_take      = (state == S_RECEIVE) && bit_strobe && demod_valid;
  assign byte_done     = bit_take && (bit_cnt == 3'd7);
  assign last_byte     = byte_done && (byte_cnt == BYTE_LAST);
  // Losing valid mid-frame is handled exactly like a sync timeout.
  assign sync_lost     = (state == S_RECEIVE) && !demod_valid;
  // A valid arriving on the final timer cycle takes precedence over the timeout.
  assign tmr_expired   = (state == S_WAIT_SYNC) && !demod_valid && (sync_tmr == TMR_LAST);
  assign retry_ok      = (retry_cnt < RETRY_MAX);
  assign handshake     = byte_valid && byte_ready;

  // State register.
  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort has top priority from every state.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_FAIL: begin
          if (start) begin
            state_nxt = S_ARM;
          end
        end
        S_ARM: begin
          if (arm_cnt == ARM_LAST) begin
            state_nxt = S_WAIT_SYNC;
          end
        end
        S_WAIT_SYNC: begin
          if (demod_valid) begin
            state_nxt = S_RECEIVE;
          end else if (tmr_expired) begin
            state_nxt = retry_ok ? S_ARM : S_FAIL;
          end
        end
        S_RECEIVE: begin
          if (sync_lost) begin
            state_nxt = retry_ok ? S_ARM : S_FAIL;
          end else if (last_byte) begin
            state_nxt = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (handshake) begin
            state_nxt = S_IDLE;
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Moore outputs decoded from the current state; the demodulator runs only while
  // we are looking for or consuming a frame.
  always_comb begin
    busy        = 1'b1;
    sync_fail   = 1'b0;
    demod_rst_n = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_FAIL: begin
        busy      = 1'b0;
        sync_fail = 1'b1;
      end
      S_ARM: begin
        demod_rst_n = 1'b0;
      end
      S_WAIT_SYNC, S_RECEIVE, S_DRAIN: begin
        demod_rst_n = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Reset-hold and sync timers run only while their state persists and restart on entry.
  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      arm_cnt  <= '0;
      sync_tmr <= '0;
    end else begin
      if ((state == S_ARM) && (state_nxt == S_ARM)) begin
        arm_cnt <= arm_cnt + 1'b1;
      end else begin
        arm_cnt <= '0;
      end
      if ((state == S_WAIT_SYNC) && (state_nxt == S_WAIT_SYNC)) begin
        sync_tmr <= sync_tmr + 1'b1;
      end else begin
        sync_tmr <= '0;
      end
    end
  end

  // Bit deserialiser; any partial byte is thrown away whenever we leave RECEIVE.
  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if ((state != S_RECEIVE) || sync_lost || abort) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (bit_take) begin
      bit_cnt   <= bit_cnt + 1'b1;
      shift_reg <= {shift_reg[5:0], demod_bit};
    end
  end

  // Byte counter restarts with every (re)arm, since each fresh sync opens a new frame.
  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      byte_cnt <= '0;
    end else if (state_nxt == S_ARM) begin
      byte_cnt <= '0;
    end else if (byte_done && !abort) begin
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

  // Output byte register: a freshly completed byte wins over a same-edge acceptance,
  // so valid stays high without a gap.
  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      byte_data  <= '0;
      byte_valid <= 1'b0;
    end else if (abort) begin
      byte_valid <= 1'b0;
    end else if (byte_done) begin
      byte_data  <= {shift_reg, demod_bit};
      byte_valid <= 1'b1;
    end else if (handshake) begin
      byte_valid <= 1'b0;
    end
  end

  // Session status: sticky overflow, retry accounting and the end-of-frame pulse.
  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      overflow   <= 1'b0;
      retry_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= !abort && (state == S_DRAIN) && handshake;
      if (session_start) begin
        overflow  <= 1'b0;
        retry_cnt <= '0;
      end else if (!abort) begin
        if (byte_done && byte_valid && !byte_ready) begin
          overflow <= 1'b1;
        end
        if ((tmr_expired || sync_lost) && retry_ok) begin
          retry_cnt <= retry_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_demod_frame_ctrl.sv
// tb_demod_frame_ctrl: directed bench for demod_frame_ctrl with a short sync timeout.
module tb_demod_frame_ctrl;

  localparam int RST_CYCLES   = 16;
  localparam int SYNC_TIMEOUT = 100;
  localparam int FRAME_BYTES  = 8;
  localparam int MAX_RETRY    = 3;

  logic       clk_fast;
  logic       rst;
  logic       start;
  logic       abort;
  logic       demod_valid;
  logic       demod_bit;
  logic       bit_strobe;
  logic       demod_rst_n;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       frame_done;
  logic       busy;
  logic       sync_fail;
  logic       overflow;
  logic [2:0] retry_cnt;

  int tests_run;
  int tests_failed;

  logic [7:0] pat_a [8];
  logic [7:0] pat_b [8];

  logic [7:0] rx_q [$];
  int         arm_runs [$];
  int         wait_runs [$];
  int         retry_seq [$];
  int         arm_len;
  int         wait_len;
  int         done_cnt;
  logic [2:0] last_retry;

  demod_frame_ctrl #(
    .RST_CYCLES  (RST_CYCLES),
    .SYNC_TIMEOUT(SYNC_TIMEOUT),
    .FRAME_BYTES (FRAME_BYTES),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clk_fast   (clk_fast),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .demod_valid(demod_valid),
    .demod_bit  (demod_bit),
    .bit_strobe (bit_strobe),
    .demod_rst_n(demod_rst_n),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .frame_done (frame_done),
    .busy       (busy),
    .sync_fail  (sync_fail),
    .overflow   (overflow),
    .retry_cnt  (retry_cnt)
  );

  // Free-running clock.
  initial begin
    clk_fast = 1'b0;
    forever #5 clk_fast = ~clk_fast;
  end

  // Hard stop in case a bounded wait is somehow bypassed.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic v, input logic r);
    start       = s;
    abort       = a;
    demod_valid = v;
    byte_ready  = r;
  endtask

  task automatic resetMonitors();
    rx_q.delete();
    arm_runs.delete();
    wait_runs.delete();
    retry_seq.delete();
    arm_len    = 0;
    wait_len   = 0;
    done_cnt   = 0;
    last_retry = retry_cnt;
  endtask

  // One clock: observe the DUT at the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clk_fast);
    if (byte_valid && byte_ready) rx_q.push_back(byte_data);
    if (frame_done) done_cnt++;
    if (busy && !demod_rst_n) begin
      arm_len++;
    end else if (arm_len != 0) begin
      arm_runs.push_back(arm_len);
      arm_len = 0;
    end
    if (busy && demod_rst_n) begin
      wait_len++;
    end else if (wait_len != 0) begin
      wait_runs.push_back(wait_len);
      wait_len = 0;
    end
    if (retry_cnt != last_retry) begin
      retry_seq.push_back(int'(retry_cnt));
      last_retry = retry_cnt;
    end
    @(posedge clk_fast);
    #1;
  endtask

  task automatic sendBit(input logic b);
    demod_bit  = b;
    bit_strobe = 1'b1;
    tick();
    bit_strobe = 1'b0;
    tick();
  endtask

  task automatic sendBits(input logic [7:0] b, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) sendBit(b[i]);
  endtask

  task automatic startSession(input logic ready);
    applyStimulus(1'b1, 1'b0, 1'b0, ready);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, ready);
  endtask

  task automatic waitRstRelease(input string tag, input int bound);
    int n;
    n = 0;
    while (!demod_rst_n && (n < bound)) begin
      tick();
      n++;
    end
    checkOutput(tag, {31'd0, demod_rst_n}, 32'd1);
  endtask

  task automatic checkRx(input string tag, input logic [7:0] exp_bytes [8], input int first);
    checkOutput({tag, "_count"}, rx_q.size(), 8 - first);
    for (int k = 0; k < 8 - first; k++) begin
      checkOutput({tag, "_byte"}, (k < rx_q.size()) ? {24'd0, rx_q[k]} : 32'hFFFF_FFFF,
                  {24'd0, exp_bytes[first + k]});
    end
  endtask

  task automatic checkRuns(input string tag, input int runs [$], input int n, input int len);
    checkOutput({tag, "_count"}, runs.size(), n);
    for (int k = 0; k < n; k++) begin
      checkOutput({tag, "_len"}, (k < runs.size()) ? runs[k] : -1, len);
    end
  endtask

  initial begin
    int n;
    logic reached;
    tests_run    = 0;
    tests_failed = 0;
    pat_a = '{8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h81, 8'h7E};
    pat_b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1};
    demod_bit  = 1'b0;
    bit_strobe = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset values.
    rst = 1'b0;
    repeat (3) @(posedge clk_fast);
    #1;
    checkOutput("rst_demod_rst_n", {31'd0, demod_rst_n}, 32'd0);
    checkOutput("rst_byte_data", {24'd0, byte_data}, 32'd0);
    checkOutput("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    checkOutput("rst_frame_done", {31'd0, frame_done}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_sync_fail", {31'd0, sync_fail}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("rst_retry_cnt", {29'd0, retry_cnt}, 32'd0);
    rst = 1'b1;
    tick();
    tick();

    // Clean frame: valid appears RST_CYCLES+5 cycles after start.
    resetMonitors();
    startSession(1'b1);
    checkOutput("t1_busy_arm", {31'd0, busy}, 32'd1);
    checkOutput("t1_rst_low_arm", {31'd0, demod_rst_n}, 32'd0);
    repeat (RST_CYCLES + 4) tick();
    checkOutput("t1_rst_released", {31'd0, demod_rst_n}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    for (int b = 0; b < 8; b++) sendBits(pat_a[b], 7, 0);
    repeat (3) tick();
    checkRuns("t1_arm", arm_runs, 1, RST_CYCLES);
    checkRx("t1_rx", pat_a, 0);
    checkOutput("t1_frame_done", done_cnt, 32'd1);
    checkOutput("t1_busy_end", {31'd0, busy}, 32'd0);
    checkOutput("t1_sync_fail", {31'd0, sync_fail}, 32'd0);
    checkOutput("t1_retry_cnt", {29'd0, retry_cnt}, 32'd0);
    checkOutput("t1_overflow", {31'd0, overflow}, 32'd0);

    // Sync never arrives: four arms, three retries, then FAIL.
    resetMonitors();
    startSession(1'b1);
    n = 0;
    while (!sync_fail && (n < 1000)) begin
      tick();
      n++;
    end
    checkOutput("t2_sync_fail", {31'd0, sync_fail}, 32'd1);
    tick();
    tick();
    checkRuns("t2_arm", arm_runs, 4, RST_CYCLES);
    checkRuns("t2_wait", wait_runs, 4, SYNC_TIMEOUT);
    checkOutput("t2_retry_steps", retry_seq.size(), 32'd3);
    for (int k = 0; k < 3; k++) begin
      checkOutput("t2_retry_seq", (k < retry_seq.size()) ? retry_seq[k] : -1, k + 1);
    end
    checkOutput("t2_retry_cnt", {29'd0, retry_cnt}, 32'd3);
    checkOutput("t2_busy", {31'd0, busy}, 32'd0);
    checkOutput("t2_demod_rst_n", {31'd0, demod_rst_n}, 32'd0);

    // Restart from FAIL; sync arrives only after the second timeout.
    resetMonitors();
    startSession(1'b1);
    checkOutput("t3_sync_fail_clr", {31'd0, sync_fail}, 32'd0);
    checkOutput("t3_retry_clr", {29'd0, retry_cnt}, 32'd0);
    checkOutput("t3_busy", {31'd0, busy}, 32'd1);
    n = 0;
    reached = 1'b0;
    while (!reached && (n < 1000)) begin
      tick();
      n++;
      reached = (retry_cnt == 3'd2) && demod_rst_n;
    end
    checkOutput("t3_third_window", {31'd0, reached}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    for (int b = 0; b < 8; b++) sendBits(pat_b[b], 7, 0);
    repeat (3) tick();
    checkRuns("t3_arm", arm_runs, 3, RST_CYCLES);
    checkRx("t3_rx", pat_b, 0);
    checkOutput("t3_frame_done", done_cnt, 32'd1);
    checkOutput("t3_retry_cnt", {29'd0, retry_cnt}, 32'd2);
    checkOutput("t3_sync_fail", {31'd0, sync_fail}, 32'd0);
    checkOutput("t3_busy_end", {31'd0, busy}, 32'd0);

    // Consumer stalls for 20 strobes: first byte overwritten, overflow sticks.
    resetMonitors();
    startSession(1'b0);
    waitRstRelease("t4_release", 40);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    sendBits(pat_a[0], 7, 0);
    checkOutput("t4_valid_b0", {31'd0, byte_valid}, 32'd1);
    checkOutput("t4_data_b0", {24'd0, byte_data}, {24'd0, pat_a[0]});
    sendBits(pat_a[1], 7, 4);
    checkOutput("t4_data_stable", {24'd0, byte_data}, {24'd0, pat_a[0]});
    checkOutput("t4_no_ovf_yet", {31'd0, overflow}, 32'd0);
    sendBits(pat_a[1], 3, 0);
    checkOutput("t4_overflow", {31'd0, overflow}, 32'd1);
    checkOutput("t4_data_b1", {24'd0, byte_data}, {24'd0, pat_a[1]});
    sendBits(pat_a[2], 7, 4);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    sendBits(pat_a[2], 3, 0);
    for (int b = 3; b < 8; b++) sendBits(pat_a[b], 7, 0);
    repeat (3) tick();
    checkRx("t4_rx", pat_a, 1);
    checkOutput("t4_frame_done", done_cnt, 32'd1);
    checkOutput("t4_overflow_sticky", {31'd0, overflow}, 32'd1);
    checkOutput("t4_busy_end", {31'd0, busy}, 32'd0);

    // Valid drops after 13 bits: partial byte discarded, re-arm, pending byte kept.
    resetMonitors();
    startSession(1'b0);
    checkOutput("t5_overflow_clr", {31'd0, overflow}, 32'd0);
    waitRstRelease("t5_release", 40);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    sendBits(pat_a[0], 7, 0);
    sendBits(pat_a[1], 7, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("t5_busy", {31'd0, busy}, 32'd1);
    checkOutput("t5_rearm_rst", {31'd0, demod_rst_n}, 32'd0);
    checkOutput("t5_retry_cnt", {29'd0, retry_cnt}, 32'd1);
    checkOutput("t5_pending_valid", {31'd0, byte_valid}, 32'd1);
    checkOutput("t5_pending_data", {24'd0, byte_data}, {24'd0, pat_a[0]});
    checkOutput("t5_no_overflow", {31'd0, overflow}, 32'd0);
    waitRstRelease("t5_rerelease", 40);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    sendBits(8'h66, 7, 0);
    checkOutput("t5_fresh_byte", {24'd0, byte_data}, 32'h66);
    checkOutput("t5_overwrite_ovf", {31'd0, overflow}, 32'd1);
    checkOutput("t5_valid_recv", {31'd0, byte_valid}, 32'd1);

    // Abort while receiving with a byte pending.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t6_busy", {31'd0, busy}, 32'd0);
    checkOutput("t6_byte_valid", {31'd0, byte_valid}, 32'd0);
    checkOutput("t6_demod_rst_n", {31'd0, demod_rst_n}, 32'd0);
    checkOutput("t6_sync_fail", {31'd0, sync_fail}, 32'd0);
    repeat (3) tick();
    checkOutput("t6_no_frame_done", done_cnt, 32'd0);
    checkOutput("t6_still_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
